// File: rtl/wb_regfile_pkg.sv
// Shared writeback-stage constants: WB control bit positions, register index width
// and the hardwired-zero register index.
package wb_regfile_pkg;

    localparam int DW          = 32;
    localparam int NREG        = 32;
    localparam int REG_AW      = 5;
    localparam int ZERO_REG    = 0;
    localparam int WB_REGWRITE = 0;
    localparam int WB_MEMTOREG = 1;

    typedef logic [REG_AW-1:0] reg_idx_t;

    // Returns 1 when the index names the hardwired-zero register.
    function automatic logic is_zero_reg(input reg_idx_t idx);
        return (idx == reg_idx_t'(ZERO_REG));
    endfunction

endpackage

// File: rtl/wb_regfile_array.sv
// General-purpose register storage with asynchronous clear, one write port
// and two raw (unbypassed) read ports.
module wb_regfile_array
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W = DW,
    parameter int N_REGS = NREG,
    parameter int ADDR_W = REG_AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr_a,
    input  logic [ADDR_W-1:0] i_raddr_b,
    output logic [DATA_W-1:0] o_rdata_a,
    output logic [DATA_W-1:0] o_rdata_b
);

    logic [DATA_W-1:0] r_mem [N_REGS];

    // Storage: whole array clears while rst is high; otherwise one gated write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_REGS; i++) begin
                r_mem[i] <= {DATA_W{1'b0}};
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a = r_mem[i_raddr_a];
    assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: result select, commit into the register file, bypassed ID
// read ports and a retired-write counter.
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int DW_P       = DW,
    parameter int NREG_P     = NREG,
    parameter int ZERO_REG_P = ZERO_REG
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        WbWb,
    input  logic [DW_P-1:0]   WbReadD,
    input  logic [DW_P-1:0]   WbAdr,
    input  logic [REG_AW-1:0] WbRd,
    input  logic [REG_AW-1:0] IdRs,
    input  logic [REG_AW-1:0] IdRt,
    output logic [DW_P-1:0]   IdRsData,
    output logic [DW_P-1:0]   IdRtData,
    output logic [DW_P-1:0]   WbWriteData,
    output logic              WbRegWrite,
    output logic [31:0]       RetireCnt
);

    logic [DW_P-1:0] w_wdata;
    logic            w_we;
    logic [DW_P-1:0] w_raw_a;
    logic [DW_P-1:0] w_raw_b;
    logic [31:0]     r_retire_cnt;
    logic            w_unused_rsvd;

    assign w_unused_rsvd = ^WbWb[3:2];

    assign w_wdata = WbWb[WB_MEMTOREG] ? WbReadD : WbAdr;
    assign w_we    = WbWb[WB_REGWRITE] && (WbRd != REG_AW'(ZERO_REG_P));

    wb_regfile_array #(
        .DATA_W (DW_P),
        .N_REGS (NREG_P),
        .ADDR_W (REG_AW)
    ) u_array (
        .clk       (clk),
        .rst       (rst),
        .i_we      (w_we),
        .i_waddr   (WbRd),
        .i_wdata   (w_wdata),
        .i_raddr_a (IdRs),
        .i_raddr_b (IdRt),
        .o_rdata_a (w_raw_a),
        .o_rdata_b (w_raw_b)
    );

    // Read port A: zero register wins over bypass, bypass wins over storage.
    always_comb begin
        IdRsData = w_raw_a;
        if (IdRs == REG_AW'(ZERO_REG_P)) begin
            IdRsData = {DW_P{1'b0}};
        end else if (w_we && (IdRs == WbRd)) begin
            IdRsData = w_wdata;
        end else begin
            IdRsData = w_raw_a;
        end
    end

    // Read port B: same priority as port A, evaluated independently.
    always_comb begin
        IdRtData = w_raw_b;
        if (IdRt == REG_AW'(ZERO_REG_P)) begin
            IdRtData = {DW_P{1'b0}};
        end else if (w_we && (IdRt == WbRd)) begin
            IdRtData = w_wdata;
        end else begin
            IdRtData = w_raw_b;
        end
    end

    // Retired-write counter; wraps silently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_retire_cnt <= 32'd0;
        end else if (w_we) begin
            r_retire_cnt <= r_retire_cnt + 32'd1;
        end
    end

    assign WbWriteData = w_wdata;
    assign WbRegWrite  = w_we;
    assign RetireCnt   = r_retire_cnt;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: random traffic against an array model,
// then directed reset, select, bypass, zero-register, disable and wrap checks.
module tb_wb_regfile;
    import wb_regfile_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  WbWb;
    logic [31:0] WbReadD;
    logic [31:0] WbAdr;
    logic [4:0]  WbRd;
    logic [4:0]  IdRs;
    logic [4:0]  IdRt;
    logic [31:0] IdRsData;
    logic [31:0] IdRtData;
    logic [31:0] WbWriteData;
    logic        WbRegWrite;
    logic [31:0] RetireCnt;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_regs [32];
    logic [31:0] m_cnt;
    logic [31:0] saved;

    always #5 clk = ~clk;

    wb_regfile dut (
        .clk         (clk),
        .rst         (rst),
        .WbWb        (WbWb),
        .WbReadD     (WbReadD),
        .WbAdr       (WbAdr),
        .WbRd        (WbRd),
        .IdRs        (IdRs),
        .IdRt        (IdRt),
        .IdRsData    (IdRsData),
        .IdRtData    (IdRtData),
        .WbWriteData (WbWriteData),
        .WbRegWrite  (WbRegWrite),
        .RetireCnt   (RetireCnt)
    );

    function automatic logic [31:0] m_wdata();
        return WbWb[1] ? WbReadD : WbAdr;
    endfunction

    function automatic logic m_we();
        return WbWb[0] && (WbRd != 5'd0);
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] idx);
        if (idx == 5'd0) return 32'd0;
        if (m_we() && idx == WbRd) return m_wdata();
        return m_regs[idx];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_comb(input string tag);
        chk({tag, ".wdata"}, WbWriteData, m_wdata());
        chk({tag, ".we"}, {31'd0, WbRegWrite}, {31'd0, m_we()});
        chk({tag, ".rs"}, IdRsData, m_read(IdRs));
        chk({tag, ".rt"}, IdRtData, m_read(IdRt));
        chk({tag, ".cnt"}, RetireCnt, m_cnt);
    endtask

    task automatic drive(input logic [3:0] wb, input logic [4:0] rd, input logic [31:0] rdat,
                         input logic [31:0] adr, input logic [4:0] rs, input logic [4:0] rt);
        WbWb = wb; WbRd = rd; WbReadD = rdat; WbAdr = adr; IdRs = rs; IdRt = rt;
        #1;
    endtask

    task automatic tick();
        logic        we_s;
        logic [31:0] wd_s;
        logic [4:0]  rd_s;
        we_s = m_we(); wd_s = m_wdata(); rd_s = WbRd;
        @(posedge clk);
        #1;
        if (we_s && !rst) begin
            m_regs[rd_s] = wd_s;
            m_cnt = m_cnt + 32'd1;
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_cnt = 32'd0;
        drive(4'd0, 5'd0, 32'd0, 32'd0, 5'd1, 5'd31);
        #10;
        chk("reset.cnt", RetireCnt, 32'd0);
        chk("reset.rs", IdRsData, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 1; i < 32; i++) begin
            drive(4'b0001, 5'(i), $urandom, $urandom, 5'(i), 5'((i + 1) % 32));
            chk_comb("fill");
            tick();
        end

        for (int n = 0; n < 300; n++) begin
            logic [4:0] rd_r;
            rd_r = 5'($urandom_range(0, 31));
            drive(4'($urandom), rd_r, $urandom, $urandom,
                  ($urandom_range(0, 3) == 0) ? rd_r : 5'($urandom_range(0, 31)),
                  ($urandom_range(0, 3) == 0) ? rd_r : 5'($urandom_range(0, 31)));
            chk_comb("rand");
            tick();
        end

        for (int i = 0; i < 32; i++) begin
            drive(4'd0, 5'd0, 32'd0, 32'd0, 5'(i), 5'(31 - i));
            chk("readback.rs", IdRsData, m_read(5'(i)));
            chk("readback.rt", IdRtData, m_read(5'(31 - i)));
        end

        // Asynchronous reset mid-run, checked without waiting for an edge.
        @(negedge clk);
        #2;
        rst = 1'b1;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_cnt = 32'd0;
        #1;
        chk("async.cnt", RetireCnt, 32'd0);
        for (int i = 0; i < 32; i++) begin
            drive(4'd0, 5'd0, 32'd0, 32'd0, 5'(i), 5'(31 - i));
            chk("async.rs", IdRsData, 32'd0);
            chk("async.rt", IdRtData, 32'd0);
        end
        drive(4'b0001, 5'd7, 32'd0, 32'h55, 5'd0, 5'd0);
        @(posedge clk);
        #1;
        drive(4'd0, 5'd0, 32'd0, 32'd0, 5'd7, 5'd7);
        chk("rstwrite.reg7", IdRsData, 32'd0);
        chk("rstwrite.cnt", RetireCnt, 32'd0);

        @(negedge clk);
        rst = 1'b0;
        drive(4'b0001, 5'd5, 32'd0, 32'h1234, 5'd5, 5'd0);
        chk_comb("postrst");
        tick();
        drive(4'd0, 5'd0, 32'd0, 32'd0, 5'd5, 5'd5);
        chk("postrst.reg5", IdRsData, 32'h1234);
        chk("postrst.cnt", RetireCnt, 32'd1);

        drive(4'b0011, 5'd8, 32'hDEADBEEF, 32'h11, 5'd8, 5'd0);
        chk("memtoreg.wdata", WbWriteData, 32'hDEADBEEF);
        chk_comb("memtoreg");
        tick();
        drive(4'd0, 5'd0, 32'd0, 32'd0, 5'd8, 5'd0);
        chk("memtoreg.reg8", IdRsData, 32'hDEADBEEF);

        drive(4'b0001, 5'd9, 32'd0, 32'hA5A5A5A5, 5'd9, 5'd9);
        chk("bypass.rs", IdRsData, 32'hA5A5A5A5);
        chk("bypass.rt", IdRtData, 32'hA5A5A5A5);
        tick();
        drive(4'd0, 5'd0, 32'd0, 32'd0, 5'd9, 5'd9);
        chk("bypass.reg9", IdRtData, 32'hA5A5A5A5);

        saved = m_cnt;
        drive(4'b0001, 5'd0, 32'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
        chk("zero.rs", IdRsData, 32'd0);
        chk("zero.we", {31'd0, WbRegWrite}, 32'd0);
        tick();
        drive(4'd0, 5'd0, 32'd0, 32'd0, 5'd0, 5'd0);
        chk("zero.cnt", RetireCnt, saved);
        chk("zero.reg0", IdRsData, 32'd0);

        drive(4'b0010, 5'd3, 32'h77, 32'd0, 5'd0, 5'd3);
        chk("wdis.rt", IdRtData, m_regs[3]);
        chk("wdis.we", {31'd0, WbRegWrite}, 32'd0);
        tick();
        chk("wdis.reg3", IdRtData, m_regs[3]);
        chk("wdis.cnt", RetireCnt, saved);
        drive(4'b1100, 5'd3, 32'h77, 32'h77, 5'd3, 5'd3);
        chk_comb("rsvd");
        tick();
        chk("rsvd.reg3", IdRsData, m_regs[3]);
        chk("rsvd.cnt", RetireCnt, saved);

        // Preload the counter near wrap between clock edges.
        @(negedge clk);
        force dut.r_retire_cnt = 32'hFFFFFFFE;
        #1;
        release dut.r_retire_cnt;
        #1;
        m_cnt = 32'hFFFFFFFE;
        chk("wrap.preload", RetireCnt, 32'hFFFFFFFE);
        drive(4'b0001, 5'd10, 32'd0, 32'h10, 5'd0, 5'd0);
        tick();
        chk("wrap.1", RetireCnt, 32'hFFFFFFFF);
        drive(4'b0001, 5'd11, 32'd0, 32'h11, 5'd0, 5'd0);
        tick();
        chk("wrap.2", RetireCnt, 32'h00000000);
        drive(4'b0001, 5'd12, 32'd0, 32'h12, 5'd0, 5'd0);
        tick();
        chk("wrap.3", RetireCnt, 32'h00000001);
        drive(4'd0, 5'd0, 32'd0, 32'd0, 5'd10, 5'd12);
        chk_comb("wrap.regs");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
